// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: one-hot FSM stepping fetch/decode/execute/mem/writeback,
// with memory-handshake timeout trap and a retired-instruction counter.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 mem_ready,
    input  logic                 dec_mem,
    input  logic                 dec_wb,
    input  logic                 dec_halt,
    output logic [7:0]           state,
    output logic                 mem_req,
    output logic                 mem_is_fetch,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 alu_en,
    output logic                 reg_we,
    output logic                 halted,
    output logic                 bus_error,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned WAIT_MAX = (TIMEOUT == 0) ? 1 : TIMEOUT;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [7:0] {
        S_IDLE      = 8'b0000_0001,
        S_FETCH     = 8'b0000_0010,
        S_DECODE    = 8'b0000_0100,
        S_EXECUTE   = 8'b0000_1000,
        S_MEM       = 8'b0001_0000,
        S_WRITEBACK = 8'b0010_0000,
        S_HALT      = 8'b0100_0000,
        S_ERROR     = 8'b1000_0000
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_mem_flag;
    logic                  r_wb_flag;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_next;
    logic [INSTRET_W-1:0]  r_instret;
    logic                  w_retire;
    logic                  w_timeout;
    logic                  w_waiting;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_flag <= 1'b0;
            r_wb_flag  <= 1'b0;
            r_wait     <= '0;
            r_instret  <= '0;
        end else begin
            if (r_state == S_DECODE) begin
                r_mem_flag <= dec_mem;
                r_wb_flag  <= dec_wb;
            end
            r_wait <= w_wait_next;
            if (w_retire) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
        end
    end

    // Any cycle that is not a stalled FETCH/MEM clears the counter, so every entry starts at 0.
    always_comb begin
        w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
        w_wait_next = '0;
        if (w_waiting) begin
            w_wait_next = (r_wait == WAIT_SAT) ? r_wait : r_wait + WAIT_W'(1);
        end
        w_timeout = (TIMEOUT != 0) && w_waiting && (r_wait == WAIT_LAST);
    end

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        mem_is_fetch = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        alu_en       = 1'b0;
        reg_we       = 1'b0;
        halted       = 1'b0;
        bus_error    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ready) begin
                    ir_load      = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_ERROR;
                end
            end
            S_DECODE: begin
                // HALT retires here and wins over the mem/wb flags.
                if (dec_halt) begin
                    w_retire     = 1'b1;
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_en = 1'b1;
                if (r_mem_flag) begin
                    w_state_next = S_MEM;
                end else if (r_wb_flag) begin
                    w_state_next = S_WRITEBACK;
                end else begin
                    w_retire     = 1'b1;
                    w_state_next = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    if (r_wb_flag) begin
                        w_state_next = S_WRITEBACK;
                    end else begin
                        w_retire     = 1'b1;
                        w_state_next = run ? S_FETCH : S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_ERROR;
                end
            end
            S_WRITEBACK: begin
                reg_we       = 1'b1;
                w_retire     = 1'b1;
                w_state_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERROR: begin
                bus_error = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule
